// File: rtl/alu_scrub_arbiter.sv
// Shares a five-replica voted ALU between the core and a background scrub
// sequencer, and tracks per-replica disagreements with the voted output.
module alu_scrub_arbiter #(
   parameter int unsigned IDLE_WAIT    = 8,
   parameter int unsigned VECTORS      = 16,
   parameter int unsigned FAULT_THRESH = 3,
   parameter int unsigned CNT_W        = 4,
   parameter logic [31:0] LFSR_SEED    = 32'hACE10001
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               core_req,
   input  logic [31:0]        core_a,
   input  logic [31:0]        core_b,
   input  logic [2:0]         core_cont,
   output logic               core_gnt,
   output logic [31:0]        alu_a,
   output logic [31:0]        alu_b,
   output logic [2:0]         alu_cont,
   input  logic [159:0]       rep_result,
   input  logic [4:0]         rep_zero,
   input  logic [31:0]        vote_result,
   input  logic               vote_zero,
   input  logic               clr_faults,
   output logic [5*CNT_W-1:0] fault_cnt,
   output logic [4:0]         fault_mask,
   output logic               alu_unreliable,
   output logic               scrub_busy,
   output logic               scrub_done,
   output logic [15:0]        scrub_passes
);

   localparam int unsigned IDLE_W = (IDLE_WAIT > 1) ? $clog2(IDLE_WAIT) : 1;
   localparam int unsigned VEC_W  = (VECTORS > 1) ? $clog2(VECTORS) : 1;
   localparam logic [31:0] LFSR_MASK = 32'h80200003;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {S_WAIT, S_TEST} state_t;

   state_t                      state_q, state_d;
   logic [IDLE_W-1:0]           idle_q, idle_d;
   logic [VEC_W-1:0]            vec_q, vec_d;
   logic [2:0]                  op_q, op_d;
   logic [31:0]                 lfsr_q, lfsr_d, lfsr_next;
   logic                        done_d;
   logic [15:0]                 passes_d;
   logic [2:0]                  op_code;
   logic                        issue;
   logic [4:0]                  mismatch;
   logic [4:0][CNT_W-1:0]       cnt_q, cnt_inc;
   logic [4:0]                  mask_q;
   logic [2:0]                  n_flagged;

   assign core_gnt   = core_req;
   assign scrub_busy = (state_q == S_TEST);
   assign issue      = core_req | (state_q == S_TEST);
   assign fault_cnt  = cnt_q;
   assign fault_mask = mask_q;
   assign lfsr_next  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

   // Self-test operation table: add, sub, and, or, slt
   always_comb begin
      op_code = 3'b010;
      case (op_q)
         3'd0:    op_code = 3'b010;
         3'd1:    op_code = 3'b110;
         3'd2:    op_code = 3'b000;
         3'd3:    op_code = 3'b001;
         3'd4:    op_code = 3'b111;
         default: op_code = 3'b010;
      endcase
   end

   // Core has strict priority over scrub vectors
   always_comb begin
      alu_a    = core_a;
      alu_b    = core_b;
      alu_cont = core_cont;
      if (!core_req && state_q == S_TEST) begin
         alu_a    = lfsr_q;
         alu_b    = {lfsr_q[15:0], lfsr_q[31:16]};
         alu_cont = op_code;
      end
   end

   always_comb begin
      state_d  = state_q;
      idle_d   = idle_q;
      vec_d    = vec_q;
      op_d     = op_q;
      lfsr_d   = lfsr_q;
      done_d   = 1'b0;
      passes_d = scrub_passes;
      case (state_q)
         S_WAIT: begin
            if (core_req) begin
               idle_d = '0;
            end else if (idle_q == IDLE_W'(IDLE_WAIT - 1)) begin
               state_d = S_TEST;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         S_TEST: begin
            if (core_req) begin
               // Preemption keeps vec/op/lfsr so the pass resumes in place
               state_d = S_WAIT;
               idle_d  = '0;
            end else begin
               lfsr_d = lfsr_next;
               op_d   = (op_q == 3'd4) ? 3'd0 : op_q + 3'd1;
               if (vec_q == VEC_W'(VECTORS - 1)) begin
                  vec_d    = '0;
                  done_d   = 1'b1;
                  passes_d = scrub_passes + 16'd1;
                  state_d  = S_WAIT;
                  idle_d   = '0;
               end else begin
                  vec_d = vec_q + VEC_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_WAIT;
         idle_q       <= '0;
         vec_q        <= '0;
         op_q         <= '0;
         lfsr_q       <= LFSR_SEED;
         scrub_done   <= 1'b0;
         scrub_passes <= '0;
      end else begin
         state_q      <= state_d;
         idle_q       <= idle_d;
         vec_q        <= vec_d;
         op_q         <= op_d;
         lfsr_q       <= lfsr_d;
         scrub_done   <= done_d;
         scrub_passes <= passes_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         mismatch[i] = (rep_result[32*i +: 32] != vote_result) | (rep_zero[i] != vote_zero);
         cnt_inc[i]  = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
      end
   end

   // Disagreement counters; flagged replicas are frozen, clear wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         mask_q <= '0;
      end else if (clr_faults) begin
         cnt_q  <= '0;
         mask_q <= '0;
      end else if (issue) begin
         for (int i = 0; i < 5; i++) begin
            if (!mask_q[i] && mismatch[i]) begin
               cnt_q[i] <= cnt_inc[i];
               if (cnt_inc[i] >= CNT_W'(FAULT_THRESH)) mask_q[i] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      n_flagged = '0;
      for (int i = 0; i < 5; i++) n_flagged = n_flagged + 3'(mask_q[i]);
   end

   assign alu_unreliable = (n_flagged >= 3'd3);

endmodule

// File: tb/tb_alu_scrub_arbiter.sv
// Directed bench for alu_scrub_arbiter: scrub sequencing, preemption,
// fault counting/flagging, saturation and asynchronous reset.
module tb_alu_scrub_arbiter;

   logic         clk, reset, core_req, clr_faults, vote_zero;
   logic [31:0]  core_a, core_b, vote_result;
   logic [2:0]   core_cont;
   logic [159:0] rep_result;
   logic [4:0]   rep_zero, err_mask, zerr_mask;

   logic         core_gnt, alu_unreliable, scrub_busy, scrub_done;
   logic [31:0]  alu_a, alu_b;
   logic [2:0]   alu_cont;
   logic [19:0]  fault_cnt;
   logic [4:0]   fault_mask;
   logic [15:0]  scrub_passes;

   logic         d15_gnt, d15_unrel, d15_busy, d15_done;
   logic [31:0]  d15_a, d15_b;
   logic [2:0]   d15_cont;
   logic [19:0]  d15_cnt;
   logic [4:0]   d15_mask;
   logic [15:0]  d15_passes;

   int n_vec = 0;
   int n_miss = 0;
   logic [31:0] lfsr_m;
   int op_m;
   logic [2:0] op_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

   alu_scrub_arbiter u_dut (
      .clk(clk), .reset(reset), .core_req(core_req), .core_a(core_a), .core_b(core_b),
      .core_cont(core_cont), .core_gnt(core_gnt), .alu_a(alu_a), .alu_b(alu_b),
      .alu_cont(alu_cont), .rep_result(rep_result), .rep_zero(rep_zero),
      .vote_result(vote_result), .vote_zero(vote_zero), .clr_faults(clr_faults),
      .fault_cnt(fault_cnt), .fault_mask(fault_mask), .alu_unreliable(alu_unreliable),
      .scrub_busy(scrub_busy), .scrub_done(scrub_done), .scrub_passes(scrub_passes)
   );

   alu_scrub_arbiter #(.FAULT_THRESH(15)) u_dut15 (
      .clk(clk), .reset(reset), .core_req(core_req), .core_a(core_a), .core_b(core_b),
      .core_cont(core_cont), .core_gnt(d15_gnt), .alu_a(d15_a), .alu_b(d15_b),
      .alu_cont(d15_cont), .rep_result(rep_result), .rep_zero(rep_zero),
      .vote_result(vote_result), .vote_zero(vote_zero), .clr_faults(clr_faults),
      .fault_cnt(d15_cnt), .fault_mask(d15_mask), .alu_unreliable(d15_unrel),
      .scrub_busy(d15_busy), .scrub_done(d15_done), .scrub_passes(d15_passes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Replica model: each replica equals the vote unless an error bit is set
   always_comb begin
      vote_result = 32'h0BADF00D;
      vote_zero   = 1'b0;
      for (int i = 0; i < 5; i++)
         rep_result[32*i +: 32] = vote_result ^ {31'b0, err_mask[i]};
      rep_zero = zerr_mask;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] lstep(input logic [31:0] x);
      return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
   endfunction

   task automatic wait_enter(input int n);
      for (int k = 0; k < n - 1; k++) begin
         tick();
         chk("busy_idle", scrub_busy, 1'b0);
      end
      tick();
      chk("busy_enter", scrub_busy, 1'b1);
   endtask

   task automatic run_test(input int n);
      for (int k = 0; k < n; k++) begin
         chk("busy_test", scrub_busy, 1'b1);
         chk("done_lo", scrub_done, 1'b0);
         chk("alu_a", alu_a, lfsr_m);
         chk("alu_b", alu_b, {lfsr_m[15:0], lfsr_m[31:16]});
         chk("alu_cont", alu_cont, op_tab[op_m]);
         tick();
         lfsr_m = lstep(lfsr_m);
         op_m   = (op_m + 1) % 5;
      end
   endtask

   initial begin
      reset = 1'b1; core_req = 1'b0; core_a = 32'h0; core_b = 32'h0; core_cont = 3'b0;
      clr_faults = 1'b0; err_mask = '0; zerr_mask = '0;
      #12;
      chk("rst_busy", scrub_busy, 1'b0);
      chk("rst_done", scrub_done, 1'b0);
      chk("rst_passes", scrub_passes, 16'd0);
      chk("rst_cnt", fault_cnt, 20'h0);
      chk("rst_mask", fault_mask, 5'h0);
      chk("rst_unrel", alu_unreliable, 1'b0);
      chk("gnt_lo", core_gnt, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Scrub pass 1 after 8 idle edges
      lfsr_m = 32'hACE10001; op_m = 0;
      wait_enter(8);
      chk("v0_a", alu_a, 32'hACE10001);
      chk("v0_b", alu_b, 32'h0001ACE1);
      chk("v0_cont", alu_cont, 3'b010);
      run_test(1);
      chk("v1_a", alu_a, 32'hD6508003);
      chk("v1_cont", alu_cont, 3'b110);
      run_test(15);
      chk("p1_done", scrub_done, 1'b1);
      chk("p1_busy", scrub_busy, 1'b0);
      chk("p1_passes", scrub_passes, 16'd1);
      tick();
      chk("p1_done_pulse", scrub_done, 1'b0);

      // Pass 2 preempted by the core at vec_idx 6, then resumed
      wait_enter(7);
      run_test(6);
      core_req = 1'b1; core_a = 32'd5; core_b = 32'd3; core_cont = 3'b010;
      #1;
      chk("pre_a", alu_a, 32'd5);
      chk("pre_b", alu_b, 32'd3);
      chk("pre_cont", alu_cont, 3'b010);
      chk("pre_gnt", core_gnt, 1'b1);
      tick();
      chk("pre_busy", scrub_busy, 1'b0);
      core_req = 1'b0;
      wait_enter(8);
      run_test(10);
      chk("p2_done", scrub_done, 1'b1);
      chk("p2_passes", scrub_passes, 16'd2);

      // Replica 2 disagrees on every core issue
      core_req = 1'b1;
      err_mask = 5'b00100;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("r2_cnt", fault_cnt[8 +: 4], 32'(k));
         chk("r2_mask", fault_mask, (k == 3) ? 5'b00100 : 5'b00000);
      end
      tick();
      chk("r2_frozen", fault_cnt[8 +: 4], 4'd3);
      err_mask = '0; clr_faults = 1'b1;
      tick();
      clr_faults = 1'b0;
      chk("clr_cnt", fault_cnt, 20'h0);
      chk("clr_mask", fault_mask, 5'h0);

      // Replicas 0,1,3 together, then clear overriding a mismatch
      err_mask = 5'b01011;
      tick(); tick();
      chk("m3_unrel_lo", alu_unreliable, 1'b0);
      chk("m3_cnt2", fault_cnt, 20'h02022);
      tick();
      chk("m3_mask", fault_mask, 5'b01011);
      chk("m3_cnt", fault_cnt, 20'h03033);
      chk("m3_unrel", alu_unreliable, 1'b1);
      clr_faults = 1'b1;
      tick();
      clr_faults = 1'b0; err_mask = '0;
      chk("clr2_cnt", fault_cnt, 20'h0);
      chk("clr2_mask", fault_mask, 5'h0);
      chk("clr2_unrel", alu_unreliable, 1'b0);
      chk("clr2_passes", scrub_passes, 16'd2);

      // Zero-flag-only mismatch on replica 4, threshold 3 and 15
      zerr_mask = 5'b10000;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("z4_cnt", fault_cnt[16 +: 4], 32'((k < 3) ? k : 3));
         chk("z4_mask", fault_mask, (k >= 3) ? 5'b10000 : 5'b00000);
         chk("z4_cnt15", d15_cnt[16 +: 4], 32'((k < 15) ? k : 15));
         chk("z4_mask15", d15_mask, (k >= 15) ? 5'b10000 : 5'b00000);
      end
      zerr_mask = '0;

      // Asynchronous reset in the middle of pass 3
      core_req = 1'b0; core_a = 32'h11112222; core_b = 32'h33334444; core_cont = 3'b001;
      wait_enter(8);
      run_test(10);
      #2 reset = 1'b1;
      #1;
      chk("ar_busy", scrub_busy, 1'b0);
      chk("ar_mask", fault_mask, 5'h0);
      chk("ar_cnt", fault_cnt, 20'h0);
      chk("ar_passes", scrub_passes, 16'd0);
      chk("ar_alu_a", alu_a, 32'h11112222);
      @(posedge clk); #1;
      reset = 1'b0;
      lfsr_m = 32'hACE10001; op_m = 0;
      wait_enter(8);
      chk("ar_v0_a", alu_a, 32'hACE10001);
      run_test(16);
      chk("ar_done", scrub_done, 1'b1);
      chk("ar_passes1", scrub_passes, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/alu_scrub_arbiter.md
Name: alu_scrub_arbiter

Overview:
Controller and arbiter for the five-replica voted ALU. It shares the ALU between the core datapath, which has strict priority, and a background self-test sequencer that runs during idle cycles. It checks every issued operation by comparing each replica against the voted output. It keeps per-replica disagreement counts and sticky fault flags, and raises an unreliability alarm when the voter can no longer out-vote failures.

Parameters:
IDLE_WAIT, 8, consecutive core-idle cycles required before self-test starts (>=1)
VECTORS, 16, test vectors per complete scrub pass (>=1)
FAULT_THRESH, 3, disagreement count at which a replica is flagged failed (1..2^CNT_W-1)
CNT_W, 4, width of each per-replica disagreement counter
LFSR_SEED, 32'hACE10001, LFSR reset value (nonzero)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
core_req  in  1  core wants the ALU this cycle
core_a, core_b  in  32  core operands
core_cont  in  3  core ALU control
core_gnt  out  1  core owns ALU (= core_req, combinational)
alu_a, alu_b  out  32  operands to ALU
alu_cont  out  3  control to ALU
rep_result  in  160  replica results, replica i at [32i+31:32i]
rep_zero  in  5  replica zero flags
vote_result  in  32  voted result
vote_zero  in  1  voted zero
clr_faults  in  1  synchronous clear of counters and fault mask
fault_cnt  out  5*CNT_W  per-replica disagreement counters, replica i at [CNT_W*i+:CNT_W]
fault_mask  out  5  sticky failed-replica flags
alu_unreliable  out  1  three or more replicas flagged
scrub_busy  out  1  FSM in TEST
scrub_done  out  1  one-cycle pulse when a pass completes
scrub_passes  out  16  completed passes, wraps at 16'hFFFF->0

Behaviour:
- Reset: FSM=WAIT, idle_cnt=0, vec_idx=0, op_idx=0, LFSR=LFSR_SEED. All counters, fault_mask, scrub_done and scrub_passes are 0.
- Output mux is combinational. If core_req=1, alu_* = core_*. Else if state=TEST, alu_a=lfsr, alu_b={lfsr[15:0],lfsr[31:16]}, alu_cont=op table[op_idx]. Otherwise alu_* = core_*.
- Op table, indices 0..4: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- issue = core_req | (state==TEST). test_issue = (state==TEST) & ~core_req.
- WAIT state: core_req=1 clears idle_cnt. Otherwise idle_cnt increments. When idle_cnt reaches IDLE_WAIT-1 with core_req=0, the FSM goes to TEST at that clock edge.
- TEST state:
  - core_req=1 preempts. The FSM goes to WAIT and idle_cnt is cleared. vec_idx, op_idx and the LFSR are retained, so the pass resumes where it stopped.
  - Each test_issue edge advances the LFSR (Galois, mask 32'h80200003), op_idx (mod 5) and vec_idx.
  - When vec_idx = VECTORS-1 on a test_issue edge: vec_idx is set to 0, scrub_done pulses next cycle, scrub_passes increments, and the FSM goes to WAIT with idle_cnt=0. op_idx and the LFSR are not reset.
- Checking happens on every issue edge. For each replica i with fault_mask[i]=0, mismatch_i = (rep_result_i != vote_result) | (rep_zero[i] != vote_zero).
  - On a mismatch, fault_cnt_i increments and saturates at 2^CNT_W-1.
  - If the incremented value is >= FAULT_THRESH, fault_mask[i] is set in the same edge.
  - Flagged replicas' counters are frozen.
  - Simultaneous mismatches on several replicas are all counted in that edge.
- The checker uses the ALU outputs of the same cycle; the ALU is combinational with zero latency.
- alu_unreliable = popcount(fault_mask) >= 3, decoded from registers.
- clr_faults=1 zeros all fault_cnt and fault_mask at the edge and takes priority over increments in that cycle. It does not affect the FSM, vec_idx or scrub_passes.
- No issue cycle: no counter changes.
- Reset asserted mid-pass aborts the pass immediately and returns to reset values.

Test Plan:
1. Reset, hold core_req=0 -> TEST entered on the 8th edge (scrub_busy=1). First vector: alu_a=32'hACE10001, alu_b=32'h0001ACE1, alu_cont=010. After 16 test cycles, scrub_done pulses once, scrub_passes=1, FSM=WAIT.
2. Assert core_req with core_a=5, core_b=3, core_cont=010 during TEST at vec_idx=6 -> alu_a=5 in the same cycle, core_gnt=1, scrub_busy=0 next cycle. After 8 idle cycles the pass resumes at vec_idx=6 with the LFSR state continued.
3. Force replica 2 result = vote XOR 1 on every issue -> fault_cnt_2 goes 1, 2, 3. fault_mask=5'b00100 after the 3rd issue edge. The counter stays 3 afterwards.
4. Drive mismatches on replicas 0, 1 and 3 on the same edge, three times -> fault_mask=5'b01011, alu_unreliable=1. clr_faults=1 with a mismatch in the same cycle -> all counts 0, mask 0.
5. Mismatch only on rep_zero[4] with results equal -> fault_cnt_4 increments. With FAULT_THRESH=15 and 20 mismatches, the counter stops at 15 and the mask sets at 15.
6. Assert reset mid-TEST at vec_idx=10 -> all outputs return to reset values asynchronously. After release, the next pass starts from LFSR_SEED and vec_idx=0.
